// File: rtl/stream_dma_ctrl.sv
// stream_dma_ctrl: CSR-programmed DMA that reads LEN words from SRC, streams
// them through an external processor, and writes the results to DST.
//   clk, reset_n           : single clock, synchronous active-low reset
//   avs_*                  : CSR slave (CTRL, STATUS, SRC, DST, LEN, COEFF)
//   avm_rd_*               : pipelined source read master, single-word reads
//   avm_wr_*               : destination write master, single-word writes
//   cfg_write/cfg_writedata: one-shot coefficient load into the processor
//   src_* / snk_*          : stream to / from the processor
//   irq                    : level interrupt, done AND irq_en
module stream_dma_ctrl #(
  parameter int unsigned CREDIT = 4,
  parameter int unsigned LEN_W  = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic [31:0] avm_rd_address,
  output logic        avm_rd_read,
  input  logic        avm_rd_waitrequest,
  input  logic [31:0] avm_rd_readdata,
  input  logic        avm_rd_readdatavalid,
  output logic [31:0] avm_wr_address,
  output logic        avm_wr_write,
  output logic [31:0] avm_wr_writedata,
  input  logic        avm_wr_waitrequest,
  output logic        cfg_write,
  output logic [31:0] cfg_writedata,
  output logic        src_valid,
  output logic [31:0] src_data,
  input  logic        src_ready,
  input  logic        snk_valid,
  input  logic [31:0] snk_data,
  output logic        snk_ready,
  output logic        irq
);

  localparam int unsigned PTR_W = (CREDIT > 1) ? $clog2(CREDIT) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;  // 0..CREDIT
  localparam int unsigned SUM_W = PTR_W + 3;  // pending + occupancy + presented

  typedef enum logic [1:0] {S_IDLE, S_CFG, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [31:0]      r_coeff;
  logic [LEN_W-1:0] r_len;
  logic             r_irq_en;
  logic             r_done;
  logic             r_cfg_write;

  logic             r_rd_read;
  logic [31:0]      r_rd_address;
  logic [31:0]      r_rd_ptr;
  logic [LEN_W-1:0] r_rd_left;
  logic [CNT_W-1:0] r_rd_pend;

  logic             r_wr_write;
  logic [31:0]      r_wr_address;
  logic [31:0]      r_wr_data;
  logic [31:0]      r_wr_ptr;
  logic [LEN_W-1:0] r_wr_left;
  logic [LEN_W-1:0] r_wr_acc_left;

  logic [31:0]      r_mem [CREDIT];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic             w_busy;
  logic             w_start;
  logic             w_rd_accept;
  logic             w_rd_issue;
  logic             w_push;
  logic             w_pop;
  logic             w_wr_accept;
  logic             w_snk_load;
  logic             w_last_wr;
  logic [SUM_W-1:0] w_used;
  logic             w_unused_rd;

  // Reads are side-effect free with zero wait states, so the strobe is not needed.
  assign w_unused_rd = avs_read;

  assign w_busy      = (r_state == S_CFG) || (r_state == S_RUN);
  assign w_start     = avs_write && (avs_address == 3'd0) && avs_writedata[0] &&
                       (r_state == S_IDLE);

  // Credit covers the presented read, reads in flight and words parked in the FIFO.
  assign w_used      = SUM_W'(r_rd_pend) + SUM_W'(r_count) + SUM_W'(r_rd_read);
  assign w_rd_accept = r_rd_read && !avm_rd_waitrequest;
  assign w_rd_issue  = (r_state == S_RUN) && (r_rd_left != '0) &&
                       (!r_rd_read || w_rd_accept) && (w_used < SUM_W'(CREDIT));

  // Beats with no matching accepted read (e.g. left over from before a reset) are dropped.
  assign w_push      = avm_rd_readdatavalid && (r_rd_pend != '0) && (r_state == S_RUN);
  assign w_pop       = (r_count != '0) && src_ready;

  assign w_wr_accept = r_wr_write && !avm_wr_waitrequest;
  assign snk_ready   = !r_wr_write || w_wr_accept;
  // Results beyond the programmed length (or while idle) are accepted and discarded.
  assign w_snk_load  = snk_valid && snk_ready && (r_state == S_RUN) && (r_wr_left != '0);
  assign w_last_wr   = w_wr_accept && (r_state == S_RUN) && (r_wr_acc_left == LEN_W'(1));

  assign avm_rd_read      = r_rd_read;
  assign avm_rd_address   = r_rd_address;
  assign avm_wr_write     = r_wr_write;
  assign avm_wr_address   = r_wr_address;
  assign avm_wr_writedata = r_wr_data;
  assign cfg_write        = r_cfg_write;
  assign cfg_writedata    = r_coeff;
  assign src_valid        = (r_count != '0);
  assign src_data         = r_mem[r_rptr];
  assign irq              = r_done && r_irq_en;

  // CSR read mux
  always_comb begin
    avs_readdata = '0;
    case (avs_address)
      3'd0:    avs_readdata = {30'd0, r_irq_en, 1'b0};
      3'd1:    avs_readdata = {30'd0, r_done, w_busy};
      3'd2:    avs_readdata = r_src;
      3'd3:    avs_readdata = r_dst;
      3'd4:    avs_readdata = 32'(r_len);
      3'd5:    avs_readdata = r_coeff;
      default: avs_readdata = '0;
    endcase
  end

  // CSRs, control FSM, read issue and write holding register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_src         <= '0;
      r_dst         <= '0;
      r_coeff       <= 32'd1;
      r_len         <= '0;
      r_irq_en      <= 1'b0;
      r_done        <= 1'b0;
      r_cfg_write   <= 1'b0;
      r_rd_read     <= 1'b0;
      r_rd_address  <= '0;
      r_rd_ptr      <= '0;
      r_rd_left     <= '0;
      r_rd_pend     <= '0;
      r_wr_write    <= 1'b0;
      r_wr_address  <= '0;
      r_wr_data     <= '0;
      r_wr_ptr      <= '0;
      r_wr_left     <= '0;
      r_wr_acc_left <= '0;
    end else begin
      if (avs_write) begin
        case (avs_address)
          3'd0:    r_irq_en <= avs_writedata[1];
          3'd1:    if (avs_writedata[1]) r_done <= 1'b0;
          3'd2:    if (!w_busy) r_src <= {avs_writedata[31:2], 2'b00};
          3'd3:    if (!w_busy) r_dst <= {avs_writedata[31:2], 2'b00};
          3'd4:    if (!w_busy) r_len <= avs_writedata[LEN_W-1:0];
          3'd5:    if (!w_busy) r_coeff <= avs_writedata;
          default: ;
        endcase
      end

      r_cfg_write <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_rd_ptr      <= r_src;
            r_wr_ptr      <= r_dst;
            r_rd_left     <= r_len;
            r_wr_left     <= r_len;
            r_wr_acc_left <= r_len;
            if (r_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_CFG;
              r_cfg_write <= 1'b1;
            end
          end
        end
        S_CFG:   r_state <= S_RUN;
        S_RUN: begin
          if (w_last_wr) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      // Read request stays presented until the slave drops waitrequest.
      if (w_rd_issue) begin
        r_rd_read    <= 1'b1;
        r_rd_address <= r_rd_ptr;
        r_rd_ptr     <= r_rd_ptr + 32'd4;
        r_rd_left    <= r_rd_left - LEN_W'(1);
      end else if (w_rd_accept) begin
        r_rd_read <= 1'b0;
      end
      r_rd_pend <= r_rd_pend + CNT_W'(w_rd_accept) - CNT_W'(w_push);

      // Write holding register: reloads in the same cycle the previous write is taken.
      if (w_snk_load) begin
        r_wr_write   <= 1'b1;
        r_wr_data    <= snk_data;
        r_wr_address <= r_wr_ptr;
        r_wr_ptr     <= r_wr_ptr + 32'd4;
        r_wr_left    <= r_wr_left - LEN_W'(1);
      end else if (w_wr_accept) begin
        r_wr_write <= 1'b0;
      end
      if (w_wr_accept) r_wr_acc_left <= r_wr_acc_left - LEN_W'(1);
    end
  end

  // Read-data FIFO; credit gating keeps it from overflowing.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= avm_rd_readdata;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule

// File: tb/tb_stream_dma_ctrl.sv
// tb_stream_dma_ctrl: directed bench for stream_dma_ctrl with a read-memory
// model, a write-log slave, and an identity stream processor.
module tb_stream_dma_ctrl;

  localparam int unsigned CREDIT = 4;
  localparam int unsigned LEN_W  = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic [31:0] avm_rd_address;
  logic        avm_rd_read;
  logic        avm_rd_waitrequest = 1'b0;
  logic [31:0] avm_rd_readdata = '0;
  logic        avm_rd_readdatavalid = 1'b0;
  logic [31:0] avm_wr_address;
  logic        avm_wr_write;
  logic [31:0] avm_wr_writedata;
  logic        avm_wr_waitrequest = 1'b0;
  logic        cfg_write;
  logic [31:0] cfg_writedata;
  logic        src_valid;
  logic [31:0] src_data;
  logic        src_ready;
  logic        snk_valid;
  logic [31:0] snk_data;
  logic        snk_ready;
  logic        irq;

  logic proc_en   = 1'b1;
  bit   wait_rand = 1'b0;

  // Identity processor: passes words straight from src to snk.
  assign src_ready = proc_en && snk_ready;
  assign snk_valid = proc_en && src_valid;
  assign snk_data  = src_data;

  always #5 clk = ~clk;

  stream_dma_ctrl #(.CREDIT(CREDIT), .LEN_W(LEN_W)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .avs_address         (avs_address),
    .avs_write           (avs_write),
    .avs_writedata       (avs_writedata),
    .avs_read            (avs_read),
    .avs_readdata        (avs_readdata),
    .avm_rd_address      (avm_rd_address),
    .avm_rd_read         (avm_rd_read),
    .avm_rd_waitrequest  (avm_rd_waitrequest),
    .avm_rd_readdata     (avm_rd_readdata),
    .avm_rd_readdatavalid(avm_rd_readdatavalid),
    .avm_wr_address      (avm_wr_address),
    .avm_wr_write        (avm_wr_write),
    .avm_wr_writedata    (avm_wr_writedata),
    .avm_wr_waitrequest  (avm_wr_waitrequest),
    .cfg_write           (cfg_write),
    .cfg_writedata       (cfg_writedata),
    .src_valid           (src_valid),
    .src_data            (src_data),
    .src_ready           (src_ready),
    .snk_valid           (snk_valid),
    .snk_data            (snk_data),
    .snk_ready           (snk_ready),
    .irq                 (irq)
  );

  // Source memory contents: word at 0x1000 is 1, 0x1004 is 2, ...
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) - 32'h3FF;
  endfunction

  // Bus slave models
  logic [31:0] rd_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          rd_acc_cnt  = 0;
  int          cfg_cnt     = 0;
  int          rd_stab_err = 0;
  int          wr_stab_err = 0;
  logic [31:0] cfg_last    = '0;
  bit          rd_hold = 1'b0;
  bit          wr_hold = 1'b0;
  logic [31:0] rd_hold_addr = '0;
  logic [31:0] wr_hold_addr = '0;
  logic [31:0] wr_hold_data = '0;
  bit          rst_seen = 1'b1;

  always @(posedge clk) rst_seen = !reset_n;

  always @(negedge clk) begin
    avm_rd_readdatavalid = 1'b0;
    if (rd_q.size() > 0 && (!wait_rand || $urandom_range(0, 1) == 1)) begin
      avm_rd_readdatavalid = 1'b1;
      avm_rd_readdata      = mem_word(rd_q.pop_front());
    end
    if (rd_hold && !rst_seen && (!avm_rd_read || avm_rd_address != rd_hold_addr))
      rd_stab_err++;
    if (wr_hold && !rst_seen && (!avm_wr_write || avm_wr_address != wr_hold_addr ||
                                 avm_wr_writedata != wr_hold_data))
      wr_stab_err++;
    avm_rd_waitrequest = wait_rand && ($urandom_range(0, 2) == 0);
    avm_wr_waitrequest = wait_rand && ($urandom_range(0, 2) == 0);
    rd_hold      = avm_rd_read && avm_rd_waitrequest;
    rd_hold_addr = avm_rd_address;
    wr_hold      = avm_wr_write && avm_wr_waitrequest;
    wr_hold_addr = avm_wr_address;
    wr_hold_data = avm_wr_writedata;
    if (avm_rd_read && !avm_rd_waitrequest) begin
      rd_q.push_back(avm_rd_address);
      rd_acc_cnt++;
    end
    if (avm_wr_write && !avm_wr_waitrequest) begin
      wr_addr_q.push_back(avm_wr_address);
      wr_data_q.push_back(avm_wr_writedata);
    end
    if (cfg_write) begin
      cfg_cnt++;
      cfg_last = cfg_writedata;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write     = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read    = 1'b1;
    #1;
    d           = avs_readdata;
    avs_read    = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    logic [31:0] st;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      csr_read(3'd1, st);
      seen = st[1];
    end
    check({tag, " done"}, 32'(seen), 32'd1);
  endtask

  task automatic verify_writes(input int base, input int n, input logic [31:0] src,
                               input logic [31:0] dst, input string tag);
    check({tag, " wr count"}, 32'(wr_addr_q.size() - base), 32'(n));
    if (wr_addr_q.size() >= base + n) begin
      for (int j = 0; j < n; j++) begin
        check($sformatf("%s wr%0d addr", tag, j), wr_addr_q[base + j], dst + 32'(4 * j));
        check($sformatf("%s wr%0d data", tag, j), wr_data_q[base + j],
              mem_word(src + 32'(4 * j)));
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] rst_exp [7];
    int b_wr, b_rd, b_cfg;
    bit reached;

    rst_exp = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0};

    // Reset values
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst rd_read",   32'(avm_rd_read),  32'd0);
    check("rst wr_write",  32'(avm_wr_write), 32'd0);
    check("rst cfg_write", 32'(cfg_write),    32'd0);
    check("rst src_valid", 32'(src_valid),    32'd0);
    check("rst irq",       32'(irq),          32'd0);
    check("rst snk_ready", 32'(snk_ready),    32'd1);
    reset_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 7; a++) begin
      csr_read(3'(a), rd);
      check($sformatf("rst csr%0d", a), rd, rst_exp[a]);
    end

    // Unmapped address and word-aligned pointers
    csr_write(3'd6, 32'hDEAD_BEEF);
    csr_read(3'd6, rd);  check("csr6 ignored", rd, 32'd0);
    csr_write(3'd2, 32'h0000_1003);
    csr_read(3'd2, rd);  check("src align", rd, 32'h0000_1000);
    csr_write(3'd3, 32'h0000_2001);
    csr_read(3'd3, rd);  check("dst align", rd, 32'h0000_2000);

    // Basic 4-word transfer
    csr_write(3'd4, 32'd4);
    csr_write(3'd5, 32'd400);
    b_wr = wr_addr_q.size(); b_rd = rd_acc_cnt; b_cfg = cfg_cnt;
    csr_write(3'd0, 32'd1);
    csr_read(3'd1, rd);  check("t1 busy", rd, 32'd1);
    wait_done(200, "t1");
    verify_writes(b_wr, 4, 32'h1000, 32'h2000, "t1");
    check("t1 reads",     32'(rd_acc_cnt - b_rd), 32'd4);
    check("t1 cfg count", 32'(cfg_cnt - b_cfg),   32'd1);
    check("t1 cfg data",  cfg_last,               32'd400);
    csr_read(3'd1, rd);  check("t1 status", rd, 32'd2);
    check("t1 irq off", 32'(irq), 32'd0);
    csr_write(3'd1, 32'd2);
    csr_read(3'd1, rd);  check("t1 w1c", rd, 32'd0);

    // Zero-length start with interrupt enabled
    csr_write(3'd4, 32'd0);
    b_wr = wr_addr_q.size(); b_rd = rd_acc_cnt; b_cfg = cfg_cnt;
    csr_write(3'd0, 32'd3);
    check("t2 irq", 32'(irq), 32'd1);
    csr_read(3'd1, rd);  check("t2 status", rd, 32'd2);
    csr_read(3'd0, rd);  check("t2 ctrl", rd, 32'd2);
    repeat (5) @(negedge clk);
    check("t2 reads",  32'(rd_acc_cnt - b_rd),         32'd0);
    check("t2 writes", 32'(wr_addr_q.size() - b_wr),   32'd0);
    check("t2 cfg",    32'(cfg_cnt - b_cfg),           32'd0);
    csr_write(3'd1, 32'd2);
    check("t2 irq clr", 32'(irq), 32'd0);
    csr_write(3'd0, 32'd0);

    // Credit limit with a stalled processor
    csr_write(3'd4, 32'd16);
    csr_write(3'd3, 32'h3000);
    proc_en = 1'b0;
    b_wr = wr_addr_q.size(); b_rd = rd_acc_cnt;
    csr_write(3'd0, 32'd1);
    repeat (40) @(negedge clk);
    check("t3 credit reads", 32'(rd_acc_cnt - b_rd),       32'(CREDIT));
    check("t3 src_valid",    32'(src_valid),               32'd1);
    check("t3 rd idle",      32'(avm_rd_read),             32'd0);
    check("t3 no writes",    32'(wr_addr_q.size() - b_wr), 32'd0);
    proc_en = 1'b1;
    wait_done(400, "t3");
    verify_writes(b_wr, 16, 32'h1000, 32'h3000, "t3");
    csr_write(3'd1, 32'd2);

    // Random waitrequest and read latency, 32 words
    wait_rand = 1'b1;
    csr_write(3'd4, 32'd32);
    csr_write(3'd3, 32'h4000);
    b_wr = wr_addr_q.size();
    csr_write(3'd0, 32'd1);
    wait_done(3000, "t4");
    verify_writes(b_wr, 32, 32'h1000, 32'h4000, "t4");
    check("t4 rd stable", 32'(rd_stab_err), 32'd0);
    check("t4 wr stable", 32'(wr_stab_err), 32'd0);
    csr_write(3'd1, 32'd2);

    // Writes and start while busy are ignored
    csr_write(3'd4, 32'd8);
    csr_write(3'd2, 32'h1040);
    csr_write(3'd3, 32'h5000);
    b_wr = wr_addr_q.size(); b_cfg = cfg_cnt;
    csr_write(3'd0, 32'd1);
    csr_write(3'd4, 32'd2);
    csr_write(3'd2, 32'h8000);
    csr_write(3'd0, 32'd1);
    csr_read(3'd4, rd);  check("t5 len held", rd, 32'd8);
    csr_read(3'd2, rd);  check("t5 src held", rd, 32'h1040);
    wait_done(1500, "t5");
    verify_writes(b_wr, 8, 32'h1040, 32'h5000, "t5");
    check("t5 cfg count", 32'(cfg_cnt - b_cfg), 32'd1);
    wait_rand = 1'b0;
    csr_write(3'd1, 32'd2);

    // Address wrap past 2^32
    csr_write(3'd4, 32'd4);
    csr_write(3'd2, 32'hFFFF_FFF8);
    csr_write(3'd3, 32'hFFFF_FFF8);
    b_wr = wr_addr_q.size();
    csr_write(3'd0, 32'd1);
    wait_done(200, "t6");
    verify_writes(b_wr, 4, 32'hFFFF_FFF8, 32'hFFFF_FFF8, "t6");
    csr_write(3'd1, 32'd2);

    // Reset in the middle of a transfer
    csr_write(3'd4, 32'd8);
    csr_write(3'd2, 32'h1000);
    csr_write(3'd3, 32'h6000);
    b_wr = wr_addr_q.size();
    csr_write(3'd0, 32'd1);
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      @(negedge clk);
      reached = (wr_addr_q.size() - b_wr) >= 3;
    end
    check("t7 three writes", 32'(reached), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("t7 rd_read",   32'(avm_rd_read),  32'd0);
    check("t7 wr_write",  32'(avm_wr_write), 32'd0);
    check("t7 cfg_write", 32'(cfg_write),    32'd0);
    check("t7 src_valid", 32'(src_valid),    32'd0);
    check("t7 irq",       32'(irq),          32'd0);
    check("t7 snk_ready", 32'(snk_ready),    32'd1);
    csr_read(3'd1, rd);  check("t7 status", rd, 32'd0);
    csr_read(3'd4, rd);  check("t7 len",    rd, 32'd0);
    csr_read(3'd5, rd);  check("t7 coeff",  rd, 32'd1);
    csr_read(3'd2, rd);  check("t7 src",    rd, 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    csr_write(3'd4, 32'd2);
    csr_write(3'd2, 32'h1000);
    csr_write(3'd3, 32'h7000);
    b_wr = wr_addr_q.size(); b_cfg = cfg_cnt;
    csr_write(3'd0, 32'd1);
    wait_done(200, "t7b");
    verify_writes(b_wr, 2, 32'h1000, 32'h7000, "t7b");
    check("t7b cfg count", 32'(cfg_cnt - b_cfg), 32'd1);
    check("t7b cfg data",  cfg_last,             32'd1);
    check("idle snk_ready", 32'(snk_ready),      32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_dma_ctrl.md
STREAM_DMA_CTRL -- requirements
Module: stream_dma_ctrl

Interface
REQ-001 Parameter CREDIT, default 4, meaning input FIFO depth and maximum read words in flight (power of two, at least 2).
REQ-002 Parameter LEN_W, default 16, meaning width of the transfer length register in words.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 avs_address in 3, avs_write in 1, avs_writedata in 32, avs_read in 1, avs_readdata out 32  CSR slave; zero wait states; readdata combinational from address.
REQ-006 avm_rd_address out 32, avm_rd_read out 1, avm_rd_waitrequest in 1, avm_rd_readdata in 32, avm_rd_readdatavalid in 1  source read master; pipelined; single-word transfers.
REQ-007 avm_wr_address out 32, avm_wr_write out 1, avm_wr_writedata out 32, avm_wr_waitrequest in 1  destination write master; single-word transfers.
REQ-008 cfg_write out 1, cfg_writedata out 32  coefficient port to the stream processor control slave.
REQ-009 src_valid out 1, src_data out 32, src_ready in 1  stream toward the processor sink.
REQ-010 snk_valid in 1, snk_data in 32, snk_ready out 1  stream from the processor source.
REQ-011 irq  out  1  level interrupt; equals done AND irq_en.

Function
REQ-012 The CSR map SHALL be: 0 CTRL (bit0 start, write-1 pulse; bit1 irq_en), 1 STATUS (bit0 busy RO; bit1 done, W1C), 2 SRC, 3 DST, 4 LEN (words, LEN_W bits), 5 COEFF; addresses 6-7 read as 0 and ignore writes.
REQ-013 SRC/DST bits [1:0] SHALL read as 0 and be ignored.
REQ-014 FSM states SHALL be IDLE, CFG, RUN, DONE.
REQ-015 IDLE -> CFG on start=1 write; while busy, start and writes to SRC/DST/LEN/COEFF SHALL be ignored.
REQ-016 CFG SHALL assert cfg_write for exactly one cycle with cfg_writedata = COEFF, then go to RUN.
REQ-017 LEN=0 start SHALL skip CFG/RUN: go to DONE next cycle with no bus or stream traffic.
REQ-018 RUN SHALL issue reads at SRC+4k, k=0..LEN-1; avm_rd_read and address SHALL be held stable while waitrequest=1.
REQ-019 A read SHALL be issued only when (outstanding reads + FIFO occupancy) < CREDIT; readdatavalid data SHALL be written to the FIFO unconditionally and never overflow.
REQ-020 src_valid = FIFO not empty; src_data = FIFO head; pop on src_valid&src_ready; simultaneous push and pop SHALL be allowed when full or empty.
REQ-021 snk_ready SHALL be 1 when the write holding register is empty or being accepted this cycle (avm_wr_write & !avm_wr_waitrequest).
REQ-022 Each accepted result SHALL be written to DST+4j, j=0..LEN-1, in arrival order; write and data SHALL be held while waitrequest=1.
REQ-023 RUN -> DONE when the LEN-th write is accepted; DONE sets STATUS.done, clears busy, goes to IDLE the same cycle.
REQ-024 busy SHALL be 1 in CFG and RUN, 0 otherwise.
REQ-025 Address counters SHALL wrap modulo 2^32 without error.
REQ-026 Results arriving on snk beyond LEN SHALL be accepted and discarded while idle (snk_ready=1 in IDLE).

Reset
REQ-027 On reset_n=0 at a clock edge: FSM=IDLE; SRC=DST=LEN=0; COEFF=1; irq_en=0; done=0; FIFO and counters empty.
REQ-028 During and after reset: avm_rd_read, avm_wr_write, cfg_write, src_valid, irq = 0; snk_ready=1; avs_readdata reflects reset values.
REQ-029 Reset mid-RUN SHALL abandon the transfer; late readdatavalid beats after reset SHALL be dropped.

Verification
REQ-030 SRC=0x1000, DST=0x2000, LEN=4, COEFF=400, start; memory 1,2,3,4; processor model identity -> writes 1,2,3,4 to 0x2000..0x200C; cfg_write once with 400; done=1.
REQ-031 LEN=0, irq_en=1, start -> no reads/writes/cfg_write; done and irq high 1 cycle later.
REQ-032 LEN=16, src_ready held 0 -> exactly CREDIT=4 reads issued, then no more until ready returns; no lost data.
REQ-033 Random waitrequest on both masters, LEN=32 -> addresses/data stable during wait, all 32 words correct and ordered.
REQ-034 Start with LEN=8, write LEN=2 and start while busy -> ignored; 8 words transferred.
REQ-035 reset_n=0 after 3 of 8 writes -> all outputs to reset values next cycle; new LEN=2 transfer then completes correctly.
